fft_source_collector: RTL
=========================

Name: fft_source_collector

Overview:
- Receive end of the FFT core's Avalon-ST output stream, i.e. the source side of the core, complementing the sink-side input controller.
- Accepts frames of FFT_PTS complex bins and checks sop/eop framing against a bin counter.
- Computes each bin's power, real^2 + imag^2, and forwards bins downstream through a one-stage ready/valid register slice.
- Tracks the per-frame peak bin and reports frame completion or framing errors.

Parameters:
- DATA_W, 14, width of source_real and source_imag (signed two's complement).
- FFT_PTS, 1024, bins per frame; power of two, at least 2.
- CNT_W, 10, bin index width; equals log2(FFT_PTS).
- PWR_W, 29, power width; equals 2*DATA_W+1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- source_valid  in  1  FFT output beat valid.
- source_ready  out  1  collector can accept a beat.
- source_sop  in  1  first bin of frame.
- source_eop  in  1  last bin of frame.
- source_error  in  2  core error flags; non-zero marks the beat bad.
- source_real  in  DATA_W  bin real part, signed.
- source_imag  in  DATA_W  bin imaginary part, signed.
- bin_valid  out  1  output bin valid.
- bin_ready  in  1  downstream accepts the bin.
- bin_index  out  CNT_W  index of the output bin.
- bin_power  out  PWR_W  unsigned power of the output bin.
- bin_last  out  1  output bin is index FFT_PTS-1.
- frame_done  out  1  one-cycle pulse: a frame completed cleanly.
- peak_index  out  CNT_W  index of the maximum-power bin of the last good frame.
- peak_power  out  PWR_W  power of that bin.
- frame_err  out  1  one-cycle pulse: framing or core error.
- err_code  out  2  cause, valid while frame_err is high: 01 stray beat, 10 length mismatch, 11 source_error.
- frame_count  out  16  count of good frames; wraps.

Behaviour:
- Reset (rst_n low, async): all outputs and registers go to 0, state IDLE, source_ready held 0. After release: source_ready = !bin_valid | bin_ready (combinational).
- Accepted beat: source_valid & source_ready.
- States:
  - IDLE: accepted beat with sop and no error → forward as index 0, go to IN_FRAME. Accepted beat without sop → dropped, err 01.
  - IN_FRAME: idx counts accepted beats from 0.
- Beat checks, in priority order:
  1. source_error != 0 → beat dropped, err 11, go to IDLE; sop on the same beat is ignored.
  2. sop while IN_FRAME → err 10 for the aborted frame; the beat starts a new frame as index 0 and is forwarded.
  3. eop with idx < FFT_PTS-1, or sop & eop on the same beat → dropped, err 10, go to IDLE.
  4. idx == FFT_PTS-1 without eop → dropped, err 10, go to IDLE.
  5. idx == FFT_PTS-1 with eop → forwarded with bin_last=1, frame good, go to IDLE.
- Bins already forwarded from an aborted frame are not retracted. Dropped beats never reach the output.
- Power arithmetic: sign-extend each component, square, add into PWR_W bits with no truncation. (-2^(DATA_W-1))^2 * 2 fits exactly.
- Latency: a beat accepted at edge N appears with bin_valid at N+1. bin_index, bin_power and bin_last are held stable while bin_valid & !bin_ready.
- Peak tracking:
  - Running max reset at each index-0 beat.
  - Update only on strictly greater power, so the lowest index wins ties.
  - peak_index and peak_power are updated only on a good frame, in the same cycle frame_done pulses (edge after the eop beat is accepted). An aborted frame leaves both unchanged.
- frame_done and frame_count: frame_done pulses for one cycle regardless of bin_ready; frame_count increments on the same cycle.
- frame_err: one pulse per offending beat. An aborting sop gives one pulse with 10. Simultaneous error and restart reports only the higher-priority cause.
- Async reset mid-frame discards the partial frame with no pulses.

Decomposition:
- Package fft_stream_pkg:
  - DATA_W, FFT_PTS, CNT_W, PWR_W defaults.
  - err_code constants ERR_STRAY=2'b01, ERR_LEN=2'b10, ERR_CORE=2'b11.
  - State enum {IDLE, IN_FRAME}.
- Sub-module fft_bin_power: purely combinational signed re/im → unsigned power. The top registers its result in the output slice.

Test Plan:
- Clean frame: 1024 beats, sop on beat 0, eop on beat 1023, bin k = (k,0), bin_ready=1 → 1024 bins, bin_power[k]=k^2, bin_last only at 1023, frame_done once, peak_index=1023, peak_power=1046529, frame_count=1.
- Backpressure: bin_ready toggled 1/0 every cycle → source_ready tracks it, no bin lost or duplicated, indices contiguous 0..1023, bin outputs stable while stalled.
- Early eop: eop at beat 500 → beats 0..499 forwarded, frame_err with code 10, no frame_done, peak registers unchanged.
- Missing eop and stray beat: 1024th beat without eop → err 10, that beat dropped. Next beat without sop → err 01. Following sop frame completes cleanly.
- Core error and extremes: source_error=2'b01 at beat 10 → err 11, return to IDLE. Clean frame with bins 3 and 7 both (-8192,-8192) → peak_power=134217728, peak_index=3.
- Reset mid-frame: rst_n low at beat 300 → all outputs 0 immediately, source_ready 0. After release, a new clean frame gives frame_count=1 and correct peak.

Source files
------------

// File: rtl/fft_stream_pkg.sv
// Shared parameters, error codes and FSM states for the FFT output stream.
package fft_stream_pkg;
  localparam int DATA_W  = 14;
  localparam int FFT_PTS = 1024;
  localparam int CNT_W   = 10;
  localparam int PWR_W   = 29;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_STRAY = 2'b01;
  localparam logic [1:0] ERR_LEN   = 2'b10;
  localparam logic [1:0] ERR_CORE  = 2'b11;

  typedef enum logic {IDLE, IN_FRAME} state_t;
endpackage

// File: rtl/fft_source_collector_if.sv
// Stream bundle: FFT source beats in, per-bin power out.
interface fft_source_collector_if #(
  parameter int DATA_W = 14,
  parameter int CNT_W  = 10,
  parameter int PWR_W  = 29
) ();
  logic              source_valid;
  logic              source_ready;
  logic              source_sop;
  logic              source_eop;
  logic [1:0]        source_error;
  logic [DATA_W-1:0] source_real;
  logic [DATA_W-1:0] source_imag;
  logic              bin_valid;
  logic              bin_ready;
  logic [CNT_W-1:0]  bin_index;
  logic [PWR_W-1:0]  bin_power;
  logic              bin_last;

  // Environment side: drives FFT beats, consumes bins.
  modport master (
    output source_valid, source_sop, source_eop, source_error, source_real, source_imag, bin_ready,
    input  source_ready, bin_valid, bin_index, bin_power, bin_last
  );

  // Collector side.
  modport slave (
    input  source_valid, source_sop, source_eop, source_error, source_real, source_imag, bin_ready,
    output source_ready, bin_valid, bin_index, bin_power, bin_last
  );
endinterface

// File: rtl/fft_bin_power.sv
// Combinational bin power: re^2 + im^2, exact for the full signed input range.
module fft_bin_power #(
  parameter int DATA_W = 14,
  parameter int PWR_W  = 29
) (
  input  logic [DATA_W-1:0] re,
  input  logic [DATA_W-1:0] im,
  output logic [PWR_W-1:0]  power
);
  logic signed [2*DATA_W-1:0] re_x, im_x, re_sq, im_sq;

  // Widen before squaring so the largest magnitude square (2^(2*DATA_W-2)) is exact.
  always_comb begin
    re_x  = {{DATA_W{re[DATA_W-1]}}, re};
    im_x  = {{DATA_W{im[DATA_W-1]}}, im};
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    power = PWR_W'($unsigned(re_sq)) + PWR_W'($unsigned(im_sq));
  end
endmodule

// File: rtl/fft_source_collector.sv
// FFT source-side collector: framing checks, bin power, output slice, peak tracking.
module fft_source_collector
  import fft_stream_pkg::*;
#(
  parameter int DATA_W  = fft_stream_pkg::DATA_W,
  parameter int FFT_PTS = fft_stream_pkg::FFT_PTS,
  parameter int CNT_W   = fft_stream_pkg::CNT_W,
  parameter int PWR_W   = fft_stream_pkg::PWR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_source_collector_if.slave st,
  output logic             frame_done,
  output logic [CNT_W-1:0] peak_index,
  output logic [PWR_W-1:0] peak_power,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [15:0]      frame_count
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_PTS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] idx, idx_nx, fwd_idx;
  logic             accept, fwd, fwd_last, err_nx, done_nx, new_max;
  logic [1:0]       code_nx;
  logic [PWR_W-1:0] pwr, run_max;
  logic [CNT_W-1:0] run_idx;

  // Ready stays low through reset, then follows the output slice.
  assign st.source_ready = rst_n & (!st.bin_valid | st.bin_ready);
  assign accept          = st.source_valid & st.source_ready;

  fft_bin_power #(.DATA_W(DATA_W), .PWR_W(PWR_W)) u_pwr (
    .re    (st.source_real),
    .im    (st.source_imag),
    .power (pwr)
  );

  // Beat classification and next state; checks are ordered so only one cause is reported.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    fwd      = 1'b0;
    fwd_idx  = idx;
    fwd_last = 1'b0;
    err_nx   = 1'b0;
    code_nx  = ERR_NONE;
    done_nx  = 1'b0;
    if (accept) begin
      if (st.source_error != 2'b00) begin
        err_nx = 1'b1; code_nx = ERR_CORE; state_nx = IDLE; idx_nx = '0;
      end else if (st.source_sop) begin
        if (st.source_eop) begin
          err_nx = 1'b1; code_nx = ERR_LEN; state_nx = IDLE; idx_nx = '0;
        end else begin
          // In-frame sop aborts the old frame but still starts a new one.
          err_nx   = (state == IN_FRAME);
          code_nx  = (state == IN_FRAME) ? ERR_LEN : ERR_NONE;
          fwd      = 1'b1;
          fwd_idx  = '0;
          state_nx = IN_FRAME;
          idx_nx   = CNT_W'(1);
        end
      end else if (state == IDLE) begin
        err_nx = 1'b1; code_nx = ERR_STRAY;
      end else if (st.source_eop != (idx == LAST_IDX)) begin
        err_nx = 1'b1; code_nx = ERR_LEN; state_nx = IDLE; idx_nx = '0;
      end else if (st.source_eop) begin
        fwd = 1'b1; fwd_last = 1'b1; done_nx = 1'b1; state_nx = IDLE; idx_nx = '0;
      end else begin
        fwd    = 1'b1;
        idx_nx = idx + CNT_W'(1);
      end
    end
  end

  assign new_max = (fwd_idx == '0) || (pwr > run_max);

  // FSM state and bin counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // One-stage output slice; contents hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st.bin_valid <= 1'b0;
      st.bin_index <= '0;
      st.bin_power <= '0;
      st.bin_last  <= 1'b0;
    end else if (!st.bin_valid || st.bin_ready) begin
      st.bin_valid <= fwd;
      if (fwd) begin
        st.bin_index <= fwd_idx;
        st.bin_power <= pwr;
        st.bin_last  <= fwd_last;
      end
    end
  end

  // Running max per frame; committed to the peak registers only on a good frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max     <= '0;
      run_idx     <= '0;
      peak_power  <= '0;
      peak_index  <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      if (fwd && new_max) begin
        run_max <= pwr;
        run_idx <= fwd_idx;
      end
      if (done_nx) begin
        peak_power  <= new_max ? pwr : run_max;
        peak_index  <= new_max ? fwd_idx : run_idx;
        frame_count <= frame_count + 16'd1;
      end
      frame_done <= done_nx;
      frame_err  <= err_nx;
      err_code   <= err_nx ? code_nx : ERR_NONE;
    end
  end
endmodule
